// File: rtl/rvvi_depacketizer_if.sv
// rtl/rvvi_depacketizer_if.sv - rx stream and decoded-record handshake bundle for rvvi_depacketizer
//
// Purpose: groups the 32-bit rx AXI-stream from the MAC FIFO with the decoded RVVI
// record valid/ready channel, so the depacketizer and its environment share one bundle.
//
// Signals:
//   s_axis_tdata   [31:0]          rx beat data, byte 0 in [7:0]
//   s_axis_tkeep   [3:0]           rx byte enables
//   s_axis_tvalid                  rx beat valid
//   s_axis_tready                  rx beat accept (driven by the depacketizer)
//   s_axis_tlast                   last beat of frame
//   RvviValid                      decoded record valid (driven by the depacketizer)
//   RvviReady                      consumer accept
//   Rvvi           [RVVI_WIDTH-1:0] decoded record (driven by the depacketizer)
//
// Modports:
//   slave  - depacketizer side: sinks the stream, sources the record
//   master - environment side: sources the stream, sinks the record

interface rvvi_depacketizer_if #(
  parameter int RVVI_WIDTH = 632
);
  logic [31:0]           s_axis_tdata;
  logic [3:0]            s_axis_tkeep;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic                  RvviValid;
  logic                  RvviReady;
  logic [RVVI_WIDTH-1:0] Rvvi;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tkeep,
    input  s_axis_tvalid,
    output s_axis_tready,
    input  s_axis_tlast,
    output RvviValid,
    input  RvviReady,
    output Rvvi
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tkeep,
    output s_axis_tvalid,
    input  s_axis_tready,
    output s_axis_tlast,
    input  RvviValid,
    output RvviReady,
    input  Rvvi
  );
endinterface

// File: rtl/rvvi_depacketizer.sv
// rtl/rvvi_depacketizer.sv - decodes RVVI trace Ethernet frames back into RVVI records
//
// Purpose: receive-side counterpart of the RVVI trace packetizer. Parses a 4-beat
// header (dst MAC, src MAC, EtherType, frame count) followed by PAYLOAD_WORDS payload
// beats, and presents one decoded record per good frame on a valid/ready channel.
// Frames with a wrong header or wrong length are dropped and counted.
//
// Ports:
//   m_axi_aclk      clock
//   m_axi_aresetn   asynchronous active-low reset
//   bus             rvvi_depacketizer_if.slave: rx stream in, decoded record out
//   DstMac  [47:0]  expected destination MAC (static config)
//   EthType [15:0]  expected EtherType (static config)
//   FrameCount      sequence number of the record on Rvvi
//   FrameGap        one-cycle pulse, coincident with the first RvviValid cycle, when
//                   the record's count is not previous delivered count + 1
//   BadFrame        one-cycle pulse per dropped frame
//   GoodCount       frames delivered (wraps)
//   DropCount       frames dropped (wraps)

module rvvi_depacketizer #(
  parameter  int RVVI_WIDTH        = 632,
  parameter  int FRAME_COUNT_WIDTH = 16,
  localparam int PAYLOAD_WORDS     = (RVVI_WIDTH + 31) / 32
) (
  input  logic                         m_axi_aclk,
  input  logic                         m_axi_aresetn,
  rvvi_depacketizer_if.slave           bus,
  input  logic [47:0]                  DstMac,
  input  logic [15:0]                  EthType,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic                         FrameGap,
  output logic                         BadFrame,
  output logic [31:0]                  GoodCount,
  output logic [31:0]                  DropCount
);

  // Bits of the record carried by the final payload beat; the rest of that beat is padding.
  localparam int LAST_BITS = RVVI_WIDTH - 32 * (PAYLOAD_WORDS - 1);
  // One counter walks both the header (0..3) and the payload (0..PAYLOAD_WORDS-1).
  localparam int CNT_W = (PAYLOAD_WORDS > 4) ? $clog2(PAYLOAD_WORDS) : 2;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_WORDS - 1);

  typedef enum logic [1:0] {
    HDR,
    PAY,
    DROP,
    HOLD
  } state_t;

  state_t                       state;
  state_t                       stateNext;
  logic [CNT_W-1:0]             beatCnt;
  logic [CNT_W-1:0]             cntNext;

  logic                         readyEn;
  logic                         accept;
  logic                         hdrMatch;
  logic                         dropNow;
  logic                         holdNow;
  logic                         deliverNow;

  logic [31:0]                  macLo;
  logic [15:0]                  macHi;
  logic [FRAME_COUNT_WIDTH-1:0] rxCount;
  logic [FRAME_COUNT_WIDTH-1:0] prevCount;
  logic [FRAME_COUNT_WIDTH-1:0] expectCount;
  logic                         havePrev;
  logic [RVVI_WIDTH-1:0]        record;

  // readyEn holds tready low through reset and rises on the first clock after release.
  assign bus.s_axis_tready = readyEn && (state != HOLD);
  assign bus.RvviValid     = (state == HOLD);
  assign bus.Rvvi          = record;

  assign accept      = bus.s_axis_tvalid && bus.s_axis_tready;
  assign expectCount = prevCount + 1'b1;

  // Evaluated at the beat-3 accept: dst MAC comes from beats 0/1, EtherType is live on beat 3.
  assign hdrMatch = ({macHi, macLo} == DstMac) && (bus.s_axis_tdata[15:0] == EthType);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state   <= HDR;
      beatCnt <= '0;
    end else begin
      state   <= stateNext;
      beatCnt <= cntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = beatCnt;
    dropNow    = 1'b0;
    holdNow    = 1'b0;
    deliverNow = 1'b0;

    case (state)
      HDR: begin
        if (accept) begin
          if (bus.s_axis_tlast) begin
            // Runt frame ending inside the header: discard and resync on the next beat.
            dropNow = 1'b1;
            cntNext = '0;
          end else if (beatCnt == HDR_LAST) begin
            cntNext = '0;
            if (hdrMatch) begin
              stateNext = PAY;
            end else begin
              stateNext = DROP;
              dropNow   = 1'b1;
            end
          end else begin
            cntNext = beatCnt + 1'b1;
          end
        end
      end

      PAY: begin
        if (accept) begin
          if (beatCnt == PAY_LAST) begin
            // tkeep on the final beat is irrelevant: only the low LAST_BITS are used.
            cntNext = '0;
            if (bus.s_axis_tlast) begin
              stateNext = HOLD;
              holdNow   = 1'b1;
            end else begin
              stateNext = DROP;
              dropNow   = 1'b1;
            end
          end else if (bus.s_axis_tlast || (bus.s_axis_tkeep != 4'hF)) begin
            // Short frame goes straight back to header; a partial beat mid-frame drains first.
            cntNext   = '0;
            dropNow   = 1'b1;
            stateNext = bus.s_axis_tlast ? HDR : DROP;
          end else begin
            cntNext = beatCnt + 1'b1;
          end
        end
      end

      DROP: begin
        if (accept && bus.s_axis_tlast) begin
          stateNext = HDR;
          cntNext   = '0;
        end
      end

      HOLD: begin
        if (bus.RvviReady) begin
          stateNext  = HDR;
          deliverNow = 1'b1;
        end
      end

      default: begin
        stateNext = HDR;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      readyEn    <= 1'b0;
      macLo      <= '0;
      macHi      <= '0;
      rxCount    <= '0;
      prevCount  <= '0;
      havePrev   <= 1'b0;
      record     <= '0;
      FrameCount <= '0;
      FrameGap   <= 1'b0;
      BadFrame   <= 1'b0;
      GoodCount  <= '0;
      DropCount  <= '0;
    end else begin
      readyEn  <= 1'b1;
      BadFrame <= dropNow;
      // The first record after reset has no predecessor to compare against.
      FrameGap <= holdNow && havePrev && (rxCount != expectCount);

      if (dropNow) begin
        DropCount <= DropCount + 1'b1;
      end
      if (deliverNow) begin
        GoodCount <= GoodCount + 1'b1;
      end

      if (accept && (state == HDR)) begin
        if (beatCnt == CNT_W'(0)) begin
          macLo <= bus.s_axis_tdata;
        end
        if (beatCnt == CNT_W'(1)) begin
          macHi <= bus.s_axis_tdata[15:0];
        end
        if (beatCnt == HDR_LAST) begin
          rxCount <= bus.s_axis_tdata[16 +: FRAME_COUNT_WIDTH];
        end
      end

      if (accept && (state == PAY)) begin
        for (int j = 0; j < PAYLOAD_WORDS - 1; j++) begin
          if (beatCnt == CNT_W'(j)) begin
            record[32*j +: 32] <= bus.s_axis_tdata;
          end
        end
        if (beatCnt == PAY_LAST) begin
          record[RVVI_WIDTH-1 -: LAST_BITS] <= bus.s_axis_tdata[LAST_BITS-1:0];
        end
      end

      // Only frames that reach HOLD advance the expected sequence; drops leave it alone.
      if (holdNow) begin
        FrameCount <= rxCount;
        prevCount  <= rxCount;
        havePrev   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// tb/tb_rvvi_depacketizer.sv - self-checking bench for rvvi_depacketizer

module tb_rvvi_depacketizer;

  localparam int RW = 632;
  localparam int PW = (RW + 31) / 32;
  localparam int NV = 15;
  localparam logic [47:0] DST = 48'h8F54_0000_1654;
  localparam logic [47:0] BADDST = 48'h8F54_0000_1655;
  localparam logic [47:0] SRC = 48'h0200_DEAD_BEEF;
  localparam logic [15:0] ETH = 16'h005C;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] eth;
    logic [15:0] cnt;
    int          total;
    logic [3:0]  lastKeep;
    int          badKeepAt;
    logic        expValid;
    logic        expGap;
    logic        expBad;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [15:0] frameCount;
  logic        frameGap;
  logic        badFrame;
  logic [31:0] goodCount;
  logic [31:0] dropCount;

  int nTests = 0;
  int nFail = 0;

  rvvi_depacketizer_if #(.RVVI_WIDTH(RW)) bus ();

  rvvi_depacketizer #(
    .RVVI_WIDTH       (RW),
    .FRAME_COUNT_WIDTH(16)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rstN),
    .bus          (bus),
    .DstMac       (DST),
    .EthType      (ETH),
    .FrameCount   (frameCount),
    .FrameGap     (frameGap),
    .BadFrame     (badFrame),
    .GoodCount    (goodCount),
    .DropCount    (dropCount)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge; tests look at deltas of these counters.
  int          badCnt = 0;
  int          gapCnt = 0;
  int          stallCnt = 0;
  int          recCnt = 0;
  logic [RW-1:0] lastRec = '0;
  logic [15:0] lastFc = '0;
  logic        lastGap = 1'b0;
  logic        gapAtRise = 1'b0;
  logic        prevValid = 1'b0;

  always @(negedge clk) begin
    if (rstN) begin
      if (badFrame) badCnt++;
      if (frameGap) gapCnt++;
      if (!bus.s_axis_tready) stallCnt++;
      if (bus.RvviValid && !prevValid) gapAtRise = frameGap;
      if (bus.RvviValid && bus.RvviReady) begin
        recCnt++;
        lastRec = bus.Rvvi;
        lastFc  = frameCount;
        lastGap = gapAtRise;
      end
      prevValid = bus.RvviValid;
    end else begin
      prevValid = 1'b0;
    end
  end

  function automatic logic [31:0] payWord(input logic [15:0] c, input int j);
    return {c ^ 16'h5A00, 16'(j) ^ 16'hC3A5};
  endfunction

  function automatic logic [31:0] beatWord(input logic [47:0] dst, input logic [15:0] eth,
                                           input logic [15:0] cnt, input int b);
    case (b)
      0:       return dst[31:0];
      1:       return {SRC[15:0], dst[47:32]};
      2:       return SRC[47:16];
      3:       return {cnt, eth};
      default: return payWord(cnt, b - 4);
    endcase
  endfunction

  function automatic logic [RW-1:0] expRec(input logic [15:0] c);
    logic [32*PW-1:0] p;
    for (int j = 0; j < PW; j++) p[32*j +: 32] = payWord(c, j);
    return p[RW-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chkRec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sendFrame(input logic [47:0] dst, input logic [15:0] eth, input logic [15:0] cnt,
                           input int total, input logic [3:0] lastKeep, input int badKeepAt,
                           input bit withLast);
    for (int b = 0; b < total; b++) begin
      int g;
      bus.s_axis_tdata  = beatWord(dst, eth, cnt, b);
      bus.s_axis_tkeep  = (b == total - 1) ? lastKeep : ((b == badKeepAt) ? 4'h3 : 4'hF);
      bus.s_axis_tlast  = withLast && (b == total - 1);
      bus.s_axis_tvalid = 1'b1;
      @(negedge clk);
      g = 0;
      while (!bus.s_axis_tready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) begin
        chk("beat_accept_timeout", 32'(bus.s_axis_tready), 32'd1);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_tready"}, 32'(bus.s_axis_tready), 32'd0);
    chk({tag, "_valid"}, 32'(bus.RvviValid), 32'd0);
    chkRec({tag, "_rvvi"}, bus.Rvvi, '0);
    chk({tag, "_framecount"}, 32'(frameCount), 32'd0);
    chk({tag, "_gap"}, 32'(frameGap), 32'd0);
    chk({tag, "_bad"}, 32'(badFrame), 32'd0);
    chk({tag, "_goodcount"}, goodCount, 32'd0);
    chk({tag, "_dropcount"}, dropCount, 32'd0);
  endtask

  task automatic applyReset(input string tag);
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    checkReset(tag);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_tready_after"}, 32'(bus.s_axis_tready), 32'd1);
  endtask

  vec_t vecs[NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, g0, s0, r0, viol;
    int expGood, expDrop;
    logic [RW-1:0] snap;

    vecs[0]  = '{DST,    ETH,      16'h0005, 4 + PW, 4'h7, -1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{DST,    ETH,      16'h0006, 4 + PW, 4'h7, -1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{DST,    ETH,      16'h0008, 4 + PW, 4'h7, -1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{DST,    16'h0800, 16'h0009, 4 + PW, 4'h7, -1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{DST,    ETH,      16'h0009, 4 + PW, 4'h7, -1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{DST,    ETH,      16'h000A, 15,     4'hF, -1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{DST,    ETH,      16'h000A, 4 + PW, 4'h7, -1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{DST,    ETH,      16'h000B, 5 + PW, 4'hF, -1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{DST,    ETH,      16'h000B, 4 + PW, 4'h7, -1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{BADDST, ETH,      16'h000C, 4 + PW, 4'h7, -1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{DST,    ETH,      16'h000C, 3,      4'hF, -1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{DST,    ETH,      16'h000C, 4 + PW, 4'h7, 9,  1'b0, 1'b0, 1'b1};
    vecs[12] = '{DST,    ETH,      16'hFFFF, 4 + PW, 4'h7, -1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{DST,    ETH,      16'h0000, 4 + PW, 4'h7, -1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{DST,    ETH,      16'h0001, 4 + PW, 4'h1, -1, 1'b1, 1'b0, 1'b0};

    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = 4'hF;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.RvviReady     = 1'b1;

    applyReset("por");

    // Single good frame, first after reset.
    b0 = badCnt;
    sendFrame(DST, ETH, 16'h0007, 4 + PW, 4'h7, -1, 1'b1);
    chk("single_valid_latency", 32'(bus.RvviValid), 32'd1);
    chk("single_framecount", 32'(frameCount), 32'd7);
    chk("single_gap", 32'(frameGap), 32'd0);
    chkRec("single_rvvi", bus.Rvvi, expRec(16'h0007));
    chk("single_goodcount_before", goodCount, 32'd0);
    @(posedge clk);
    #1;
    chk("single_goodcount", goodCount, 32'd1);
    chk("single_valid_after", 32'(bus.RvviValid), 32'd0);
    chk("single_bad", 32'(badCnt - b0), 32'd0);

    applyReset("rst2");
    expGood = 0;
    expDrop = 0;

    for (int i = 0; i < NV; i++) begin
      b0 = badCnt;
      g0 = gapCnt;
      s0 = stallCnt;
      r0 = recCnt;
      sendFrame(vecs[i].dst, vecs[i].eth, vecs[i].cnt, vecs[i].total, vecs[i].lastKeep,
                vecs[i].badKeepAt, 1'b1);
      chk($sformatf("v%0d_valid_latency", i), 32'(bus.RvviValid), 32'(vecs[i].expValid));
      repeat (3) @(posedge clk);
      #1;
      if (vecs[i].expValid) expGood++;
      if (vecs[i].expBad) expDrop++;
      chk($sformatf("v%0d_records", i), 32'(recCnt - r0), 32'(vecs[i].expValid));
      chk($sformatf("v%0d_badpulses", i), 32'(badCnt - b0), 32'(vecs[i].expBad));
      chk($sformatf("v%0d_gappulses", i), 32'(gapCnt - g0), 32'(vecs[i].expGap));
      chk($sformatf("v%0d_stallcycles", i), 32'(stallCnt - s0), 32'(vecs[i].expValid));
      chk($sformatf("v%0d_goodcount", i), goodCount, 32'(expGood));
      chk($sformatf("v%0d_dropcount", i), dropCount, 32'(expDrop));
      if (vecs[i].expValid) begin
        chkRec($sformatf("v%0d_rvvi", i), lastRec, expRec(vecs[i].cnt));
        chk($sformatf("v%0d_framecount", i), 32'(lastFc), 32'(vecs[i].cnt));
        chk($sformatf("v%0d_gap_at_valid", i), 32'(lastGap), 32'(vecs[i].expGap));
      end
    end

    // Consumer backpressure: record held, stream stalled.
    bus.RvviReady = 1'b0;
    r0 = recCnt;
    sendFrame(DST, ETH, 16'h0002, 4 + PW, 4'h7, -1, 1'b1);
    snap = bus.Rvvi;
    viol = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.s_axis_tready || !bus.RvviValid || (bus.Rvvi !== snap)) viol++;
    end
    chk("bp_stable_violations", 32'(viol), 32'd0);
    chk("bp_goodcount_held", goodCount, 32'(expGood));
    chkRec("bp_rvvi", snap, expRec(16'h0002));
    chk("bp_framecount", 32'(frameCount), 32'd2);
    @(posedge clk);
    #1;
    bus.RvviReady = 1'b1;
    @(posedge clk);
    #1;
    expGood++;
    chk("bp_goodcount_release", goodCount, 32'(expGood));
    chk("bp_valid_release", 32'(bus.RvviValid), 32'd0);
    chk("bp_tready_release", 32'(bus.s_axis_tready), 32'd1);
    sendFrame(DST, ETH, 16'h0003, 4 + PW, 4'h7, -1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    expGood++;
    chk("bp_next_records", 32'(recCnt - r0), 32'd2);
    chk("bp_next_framecount", 32'(lastFc), 32'd3);
    chk("bp_next_gap", 32'(lastGap), 32'd0);
    chk("bp_next_goodcount", goodCount, 32'(expGood));

    // Reset during payload beat 6, then a fresh frame.
    b0 = badCnt;
    sendFrame(DST, ETH, 16'h0004, 10, 4'hF, -1, 1'b0);
    bus.s_axis_tdata  = payWord(16'h0004, 6);
    bus.s_axis_tkeep  = 4'hF;
    bus.s_axis_tvalid = 1'b1;
    applyReset("midrst");
    r0 = recCnt;
    sendFrame(DST, ETH, 16'h1234, 4 + PW, 4'h7, -1, 1'b1);
    chk("midrst_valid_latency", 32'(bus.RvviValid), 32'd1);
    chk("midrst_gap", 32'(frameGap), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_bad", 32'(badCnt - b0), 32'd0);
    chk("midrst_dropcount", dropCount, 32'd0);
    chk("midrst_goodcount", goodCount, 32'd1);
    chk("midrst_records", 32'(recCnt - r0), 32'd1);
    chkRec("midrst_rvvi", lastRec, expRec(16'h1234));
    chk("midrst_framecount", 32'(lastFc), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
